clap_delay: RTL and testbench

- Glitch-free ("clapped") flag generator for competition/hazard-sensitive control paths.
- Detect condition: en high AND din_rvs low (din_rvs is active-low data).
- The condition is re-timed through a register pipeline of DELAY clock beats, so flag never carries the combinational glitch that en/din_rvs skew would produce.
- Sits between asynchronously skewed control inputs and downstream synchronous logic.

---
 rtl/clap_delay.sv | 61 ++++++
 tb/tb_clap_delay.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clap_delay.sv
// clap_delay: re-times the detect condition (en & ~din_rvs) through DELAY flops so that
// flag never shows en/din_rvs skew glitches. Define CLAP_DELAY_RAW_OUT_EN to add flag_raw.
module clap_delay #(
  parameter int DELAY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din_rvs,
  output logic flag,
  output logic flag_pulse
`ifdef CLAP_DELAY_RAW_OUT_EN
  ,
  output logic flag_raw
`endif
);

  if (DELAY < 1 || DELAY > 16) begin : g_delay_range_check
    $error("clap_delay: DELAY must be in the range 1..16");
  end

  logic             cond;
  logic [DELAY-1:0] stage_q;
  logic [DELAY-1:0] stage_d;
  logic             flag_pulse_q;
  logic             flag_pulse_d;

  // Only ever used as the D input of stage 0; it may glitch between edges.
  assign cond = en & ~din_rvs;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = cond;
    for (int i = 1; i < DELAY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    // Rising edge of flag as seen at this clock edge: next value high, current value low.
    flag_pulse_d = stage_d[DELAY-1] & ~stage_q[DELAY-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q      <= '0;
      flag_pulse_q <= 1'b0;
    end else begin
      stage_q      <= stage_d;
      flag_pulse_q <= flag_pulse_d;
    end
  end

  assign flag       = stage_q[DELAY-1];
  assign flag_pulse = flag_pulse_q;

`ifdef CLAP_DELAY_RAW_OUT_EN
  // Debug view of the unregistered hazard path.
  assign flag_raw = cond;
`endif

endmodule

// File: tb/tb_clap_delay.sv
// Directed bench for clap_delay: reset, hazard skew, latency sweep (DELAY=1,2,5),
// toggle pattern, mid-run reset and, when CLAP_DELAY_RAW_OUT_EN is defined, flag_raw.
module tb_clap_delay;

  logic clk;
  logic rst;
  logic en;
  logic din_rvs;

  logic d1_flag, d1_pulse;
  logic d2_flag, d2_pulse;
  logic d5_flag, d5_pulse;
`ifdef CLAP_DELAY_RAW_OUT_EN
  logic d1_raw, d2_raw, d5_raw;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  clap_delay #(.DELAY(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .din_rvs(din_rvs),
    .flag(d1_flag), .flag_pulse(d1_pulse)
`ifdef CLAP_DELAY_RAW_OUT_EN
    , .flag_raw(d1_raw)
`endif
  );

  clap_delay #(.DELAY(2)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .din_rvs(din_rvs),
    .flag(d2_flag), .flag_pulse(d2_pulse)
`ifdef CLAP_DELAY_RAW_OUT_EN
    , .flag_raw(d2_raw)
`endif
  );

  clap_delay #(.DELAY(5)) u_d5 (
    .clk(clk), .rst(rst), .en(en), .din_rvs(din_rvs),
    .flag(d5_flag), .flag_pulse(d5_pulse)
`ifdef CLAP_DELAY_RAW_OUT_EN
    , .flag_raw(d5_raw)
`endif
  );

  // Rising edges at 10, 20, 30 ns ...
  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1;
      #5 clk = 1'b0;
      #5;
    end
  end

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pat, d1_f_exp, d1_p_exp, d2_f_exp, d2_p_exp;

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    din_rvs = 1'b0;

    // Reset held for two edges with the condition true.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_d1_flag", d1_flag, 1'b0);
      check("rst_d2_flag", d2_flag, 1'b0);
      check("rst_d2_pulse", d2_pulse, 1'b0);
      check("rst_d5_flag", d5_flag, 1'b0);
    end
    rst = 1'b0;
    tick();
    check("rel1_d1_flag", d1_flag, 1'b1);
    check("rel1_d1_pulse", d1_pulse, 1'b1);
    check("rel1_d2_flag", d2_flag, 1'b0);
    check("rel1_d2_pulse", d2_pulse, 1'b0);
    tick();
    check("rel2_d2_flag", d2_flag, 1'b1);
    check("rel2_d2_pulse", d2_pulse, 1'b1);
    check("rel2_d1_pulse", d1_pulse, 1'b0);
    tick();
    check("rel3_d2_flag", d2_flag, 1'b1);
    check("rel3_d2_pulse", d2_pulse, 1'b0);

    // Hazard skew: en rises 1 ns before an edge, din_rvs falls 1 ns after it.
    en      = 1'b0;
    din_rvs = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("hz_idle_d2_flag", d2_flag, 1'b0);
    #8 en = 1'b1;
    @(posedge clk);
    #1 din_rvs = 1'b0;
    check("hz_e0_d2_flag", d2_flag, 1'b0);
    check("hz_e0_d2_pulse", d2_pulse, 1'b0);
    check("hz_e0_d1_flag", d1_flag, 1'b0);
    tick();
    check("hz_e1_d2_flag", d2_flag, 1'b0);
    check("hz_e1_d2_pulse", d2_pulse, 1'b0);
    check("hz_e1_d1_flag", d1_flag, 1'b1);
    tick();
    check("hz_e2_d2_flag", d2_flag, 1'b1);
    check("hz_e2_d2_pulse", d2_pulse, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hz_hold_d2_flag", d2_flag, 1'b1);
      check("hz_hold_d2_pulse", d2_pulse, 1'b0);
    end

    // Latency sweep: single-cycle condition pulse sampled at edge k.
    en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("sw_idle_d5_flag", d5_flag, 1'b0);
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int j = 0; j < 7; j++) begin
      check("sw_d1_flag", d1_flag, logic'(j == 0));
      check("sw_d1_pulse", d1_pulse, logic'(j == 0));
      check("sw_d2_flag", d2_flag, logic'(j == 1));
      check("sw_d2_pulse", d2_pulse, logic'(j == 1));
      check("sw_d5_flag", d5_flag, logic'(j == 4));
      check("sw_d5_pulse", d5_pulse, logic'(j == 4));
      tick();
    end

    // Toggle pattern 1,0,1,1,0 (bit t = value sampled at edge t).
    pat      = 8'b0000_1101;
    d1_f_exp = 8'b0000_1101;
    d1_p_exp = 8'b0000_0101;
    d2_f_exp = 8'b0001_1010;
    d2_p_exp = 8'b0000_1010;
    for (int t = 0; t < 8; t++) begin
      en = pat[t];
      tick();
      check("tg_d1_flag", d1_flag, d1_f_exp[t]);
      check("tg_d1_pulse", d1_pulse, d1_p_exp[t]);
      check("tg_d2_flag", d2_flag, d2_f_exp[t]);
      check("tg_d2_pulse", d2_pulse, d2_p_exp[t]);
    end

    // Mid-run reset with the condition held true.
    en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("mr_pre_d2_flag", d2_flag, 1'b1);
    check("mr_pre_d5_flag", d5_flag, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_rst_d2_flag", d2_flag, 1'b0);
    check("mr_rst_d2_pulse", d2_pulse, 1'b0);
    check("mr_rst_d5_flag", d5_flag, 1'b0);
    tick();
    check("mr_r1_d2_flag", d2_flag, 1'b0);
    check("mr_r1_d2_pulse", d2_pulse, 1'b0);
    check("mr_r1_d1_flag", d1_flag, 1'b1);
    tick();
    check("mr_r2_d2_flag", d2_flag, 1'b1);
    check("mr_r2_d2_pulse", d2_pulse, 1'b1);
    tick();
    check("mr_r3_d2_pulse", d2_pulse, 1'b0);
    check("mr_r3_d5_flag", d5_flag, 1'b0);
    tick();
    tick();
    check("mr_r5_d5_flag", d5_flag, 1'b1);
    check("mr_r5_d5_pulse", d5_pulse, 1'b1);

`ifdef CLAP_DELAY_RAW_OUT_EN
    // Raw path follows inputs between edges; registered flag does not.
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("raw_idle", d2_raw, 1'b0);
    #2 en = 1'b1;
    din_rvs = 1'b0;
    #1;
    check("raw_now", d2_raw, 1'b1);
    check("raw_flag_held", d2_flag, 1'b0);
    din_rvs = 1'b1;
    #1;
    check("raw_drop", d2_raw, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
